// File: rtl/block_framer_if.sv
// Sample, scaling-factor, control and framed-output signals of the block framer.
interface block_framer_if;
  logic [31:0] inData;
  logic        inValid;
  logic        inReady;
  logic [11:0] sfData;
  logic        sfLoad;
  logic [11:0] ctrlData;
  logic        ctrlValid;
  logic        ctrlReady;
  logic [31:0] outData;
  logic        outValid;
  logic        frameStart;

  modport master (
    output inData, inValid, sfData, sfLoad, ctrlData, ctrlValid,
    input  inReady, ctrlReady, outData, outValid, frameStart
  );

  modport slave (
    input  inData, inValid, sfData, sfLoad, ctrlData, ctrlValid,
    output inReady, ctrlReady, outData, outValid, frameStart
  );
endinterface

// File: rtl/block_framer.sv
// Block framer: one comma word then BLOCK_SIZE-1 payload words whose top nibble
// carries the scaling factor followed by control words, with comma bytes escaped.
module block_framer #(
  parameter int unsigned BLOCK_SIZE = 1024,
  parameter logic [31:0] COMMA_WORD = 32'h0000_00FC
) (
  input  logic          clk,
  input  logic          rst,
  block_framer_if.slave bus
);

  localparam int unsigned CNT_W  = ($clog2(BLOCK_SIZE) < 10) ? 10 : $clog2(BLOCK_SIZE);
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SF_W   = 12;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LO_W   = SF_W - NIB_W;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [CNT_W-1:0] GROUP_LEN   = CNT_W'(3);
  localparam logic [7:0]       COMMA_BYTE  = 8'hFC;
  localparam logic [7:0]       ESCAPE_BYTE = 8'hFD;

  typedef enum logic [1:0] {
    ST_COMMA = 2'd0,
    ST_SF    = 2'd1,
    ST_CTRL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        nib_idx_q, nib_idx_d;
  logic [SF_W-1:0]   sf_shadow_q, sf_shadow_d;
  logic [SF_W-1:0]   sf_active_q, sf_active_d;
  logic [LO_W-1:0]   ctrl_lo_q, ctrl_lo_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              in_ready_q, in_ready_d;

  logic              accept;
  logic              last_beat;
  logic              ctrl_room;
  logic              ctrl_take;
  logic [NIB_W-1:0]  nibble;
  logic [WORD_W-1:0] merged;

  // Any payload byte that would look like the comma byte is bumped by one.
  function automatic logic [WORD_W-1:0] escape_comma(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
    for (int b = 0; b < 4; b++) begin
      if (w[b*8 +: 8] == COMMA_BYTE) r[b*8 +: 8] = ESCAPE_BYTE;
    end
    return r;
  endfunction

  assign accept    = bus.inValid && in_ready_q;
  assign last_beat = (cnt_q + CNT_W'(1)) == LAST_CNT;
  assign ctrl_room = (LAST_CNT - cnt_q) >= GROUP_LEN;
  // A control word is only taken when all three of its nibbles fit in this frame.
  assign ctrl_take = accept && (state_q == ST_CTRL) && (nib_idx_q == 2'd0) && ctrl_room;

  assign bus.inReady    = in_ready_q;
  assign bus.ctrlReady  = ctrl_take && !rst;
  assign bus.outData    = out_data_q;
  assign bus.outValid   = out_valid_q;
  assign bus.frameStart = frame_start_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_COMMA;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COMMA: state_d = ST_SF;
      ST_SF: begin
        if (accept) begin
          if (last_beat)               state_d = ST_COMMA;
          else if (nib_idx_q == 2'd2)  state_d = ST_CTRL;
        end
      end
      ST_CTRL: begin
        if (accept && last_beat) state_d = ST_COMMA;
      end
      default: state_d = ST_COMMA;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    nib_idx_d     = nib_idx_q;
    sf_active_d   = sf_active_q;
    ctrl_lo_d     = ctrl_lo_q;
    sf_shadow_d   = bus.sfLoad ? bus.sfData : sf_shadow_q;
    out_data_d    = out_data_q;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    in_ready_d    = (state_d != ST_COMMA);
    nibble        = '0;
    merged        = bus.inData;

    case (state_q)
      ST_SF: begin
        case (nib_idx_q)
          2'd0:    nibble = sf_active_q[11:8];
          2'd1:    nibble = sf_active_q[7:4];
          default: nibble = sf_active_q[3:0];
        endcase
      end
      ST_CTRL: begin
        case (nib_idx_q)
          2'd0:    nibble = (ctrl_take && bus.ctrlValid) ? bus.ctrlData[11:8] : '0;
          2'd1:    nibble = ctrl_lo_q[7:4];
          default: nibble = ctrl_lo_q[3:0];
        endcase
      end
      default: nibble = '0;
    endcase

    if (state_q == ST_COMMA) begin
      // An sfLoad coinciding with the comma applies to the frame being started.
      out_data_d    = COMMA_WORD;
      out_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      cnt_d         = '0;
      nib_idx_d     = 2'd0;
      ctrl_lo_d     = '0;
      sf_active_d   = bus.sfLoad ? bus.sfData : sf_shadow_q;
    end else if (accept) begin
      merged[31:28] = nibble;
      out_data_d    = escape_comma(merged);
      out_valid_d   = 1'b1;
      cnt_d         = cnt_q + CNT_W'(1);
      nib_idx_d     = (nib_idx_q == 2'd2) ? 2'd0 : nib_idx_q + 2'd1;
      if ((state_q == ST_CTRL) && (nib_idx_q == 2'd0)) begin
        ctrl_lo_d = (ctrl_take && bus.ctrlValid) ? bus.ctrlData[7:0] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      nib_idx_q     <= 2'd0;
      sf_shadow_q   <= '0;
      sf_active_q   <= '0;
      ctrl_lo_q     <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      nib_idx_q     <= nib_idx_d;
      sf_shadow_q   <= sf_shadow_d;
      sf_active_q   <= sf_active_d;
      ctrl_lo_q     <= ctrl_lo_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      in_ready_q    <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_block_framer.sv
// Self-checking bench for block_framer: directed vector table, frame-length
// sequences, mid-frame reset and randomized traffic against a frame-position model.
module tb_block_framer;

  localparam int unsigned BS    = 1024;
  localparam int          NPAY  = BS - 1;
  localparam logic [31:0] COMMA = 32'h0000_00FC;
  localparam int          NVEC  = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_framer_if bus();

  block_framer #(.BLOCK_SIZE(BS), .COMMA_WORD(COMMA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        sfl;
    logic [11:0] sfd;
    logic        cv;
    logic [11:0] cd;
    logic        exp_ir;
    logic        exp_cr;
    logic        exp_v;
    logic        exp_fs;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vt [NVEC];

  // Frame-position reference model state.
  bit          m_comma;
  int          m_pos;
  logic [11:0] m_shadow, m_sf, m_ctrl;
  logic [31:0] m_data;
  bit          m_valid, m_fs;

  int pay_cnt, last_len, fs_seen;

  task automatic check1(input string nm, input logic act, input logic want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, want, $time);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic sfl,
                              input logic [11:0] sfd, input logic cv, input logic [11:0] cd,
                              input logic ir, input logic cr, input logic v, input logic fs,
                              input logic [31:0] od);
    vec_t r;
    r.iv = iv; r.d = d; r.sfl = sfl; r.sfd = sfd; r.cv = cv; r.cd = cd;
    r.exp_ir = ir; r.exp_cr = cr; r.exp_v = v; r.exp_fs = fs; r.exp_d = od;
    return r;
  endfunction

  function automatic logic [31:0] esc(input logic [31:0] w);
    logic [7:0] by [4];
    for (int i = 0; i < 4; i++) begin
      by[i] = w[i*8 +: 8];
      if (by[i] == 8'hFC) by[i] = 8'hFD;
    end
    return {by[3], by[2], by[1], by[0]};
  endfunction

  task automatic model_reset();
    m_comma = 1; m_pos = 0; m_shadow = '0; m_sf = '0; m_ctrl = '0;
    m_data = '0; m_valid = 0; m_fs = 0;
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] d, input logic sfl,
                       input logic [11:0] sfd, input logic cv, input logic [11:0] cd);
    rst = r; bus.inValid = iv; bus.inData = d; bus.sfLoad = sfl;
    bus.sfData = sfd; bus.ctrlValid = cv; bus.ctrlData = cd;
  endtask

  // One clock of model-checked traffic.
  task automatic run_cycle(input logic do_rst, input logic iv, input logic [31:0] d,
                           input logic sfl, input logic [11:0] sfd,
                           input logic cv, input logic [11:0] cd);
    logic        exp_cr;
    logic [11:0] t;
    int          k, g;
    @(negedge clk);
    drive(do_rst, iv, d, sfl, sfd, cv, cd);
    #1;
    exp_cr = 1'b0;
    if (do_rst) begin
      model_reset();
    end else begin
      check1("in_ready", bus.inReady, !m_comma);
      if (m_comma) begin
        m_sf = sfl ? sfd : m_shadow;
        m_data = COMMA; m_valid = 1; m_fs = 1; m_pos = 0; m_comma = 0;
      end else begin
        m_fs = 0;
        m_valid = iv;
        if (iv) begin
          k = m_pos;
          if (k < 3) begin
            t = m_sf >> (4 * (2 - k));
          end else begin
            g = (k - 3) % 3;
            if (g == 0) begin
              exp_cr = ((NPAY - k) >= 3);
              m_ctrl = (exp_cr && cv) ? cd : 12'h000;
            end
            t = m_ctrl >> (4 * (2 - g));
          end
          m_data = esc({t[3:0], d[27:0]});
          m_pos++;
          if (m_pos == NPAY) m_comma = 1;
        end
      end
      if (sfl) m_shadow = sfd;
    end
    check1("ctrl_ready", bus.ctrlReady, exp_cr);
    @(posedge clk);
    #1;
    check1("out_valid", bus.outValid, m_valid);
    check1("frame_start", bus.frameStart, m_fs);
    if (m_valid || do_rst) check32("out_data", bus.outData, m_data);
    if (do_rst) check1("in_ready_rst", bus.inReady, 1'b0);
    if (bus.frameStart) begin
      last_len = pay_cnt; pay_cnt = 0; fs_seen++;
    end else if (bus.outValid) begin
      pay_cnt++;
    end
  endtask

  task automatic reset_model_phase(input int cycles);
    for (int i = 0; i < cycles; i++) run_cycle(1, 1, $urandom, 1, 12'hFFF, 1, 12'hFFF);
    pay_cnt = 0; last_len = 0; fs_seen = 0;
  endtask

  initial begin
    int  pay_seen;
    bit  got_fs;

    drive(1, 1, 32'hFFFF_FFFF, 1, 12'hFFF, 1, 12'hFFF);
    model_reset();

    // Directed reset: everything quiet while rst is high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check1("rst ctrl_ready", bus.ctrlReady, 1'b0);
      @(posedge clk);
      #1;
      check32("rst out_data", bus.outData, 32'h0);
      check1("rst out_valid", bus.outValid, 1'b0);
      check1("rst frame_start", bus.frameStart, 1'b0);
      check1("rst in_ready", bus.inReady, 1'b0);
    end

    vt[0]  = mk(1, 32'hDEAD_BEEF, 1, 12'hA5C, 0, 12'h000, 0, 0, 1, 1, 32'h0000_00FC);
    vt[1]  = mk(1, 32'h0123_4567, 0, 12'h000, 0, 12'h000, 1, 0, 1, 0, 32'hA123_4567);
    vt[2]  = mk(1, 32'h0123_4567, 1, 12'h777, 0, 12'h000, 1, 0, 1, 0, 32'h5123_4567);
    vt[3]  = mk(1, 32'h0123_4567, 0, 12'h000, 0, 12'h000, 1, 0, 1, 0, 32'hC123_4567);
    vt[4]  = mk(1, 32'h0123_4567, 0, 12'h000, 1, 12'h3E7, 1, 1, 1, 0, 32'h3123_4567);
    vt[5]  = mk(1, 32'h0FFF_FFFF, 0, 12'h000, 1, 12'h3E7, 1, 0, 1, 0, 32'hEFFF_FFFF);
    vt[6]  = mk(1, 32'h1234_5678, 0, 12'h000, 1, 12'h3E7, 1, 0, 1, 0, 32'h7234_5678);
    vt[7]  = mk(1, 32'h00FC_12FC, 0, 12'h000, 0, 12'h3E7, 1, 1, 1, 0, 32'h00FD_12FD);
    vt[8]  = mk(0, 32'h5555_5555, 0, 12'h000, 1, 12'hABC, 1, 0, 0, 0, 32'h0000_0000);
    vt[9]  = mk(1, 32'hF0FC_FCFC, 0, 12'h000, 1, 12'hABC, 1, 0, 1, 0, 32'h00FD_FDFD);
    vt[10] = mk(1, 32'hFCFC_FCFC, 0, 12'h000, 0, 12'h000, 1, 0, 1, 0, 32'h0CFD_FDFD);
    vt[11] = mk(1, 32'h0C00_0000, 0, 12'h000, 1, 12'hF00, 1, 1, 1, 0, 32'hFD00_0000);
    vt[12] = mk(1, 32'h0C00_0000, 0, 12'h000, 0, 12'h000, 1, 0, 1, 0, 32'h0C00_0000);
    vt[13] = mk(1, 32'h1C00_0000, 0, 12'h000, 0, 12'h000, 1, 0, 1, 0, 32'h0C00_0000);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(0, vt[i].iv, vt[i].d, vt[i].sfl, vt[i].sfd, vt[i].cv, vt[i].cd);
      #1;
      check1($sformatf("vec%0d in_ready", i), bus.inReady, vt[i].exp_ir);
      check1($sformatf("vec%0d ctrl_ready", i), bus.ctrlReady, vt[i].exp_cr);
      @(posedge clk);
      #1;
      check1($sformatf("vec%0d out_valid", i), bus.outValid, vt[i].exp_v);
      check1($sformatf("vec%0d frame_start", i), bus.frameStart, vt[i].exp_fs);
      if (vt[i].exp_v) check32($sformatf("vec%0d out_data", i), bus.outData, vt[i].exp_d);
    end

    // Finish the frame: 12 payloads so far, total must be 1023; mid-frame sfLoad lands next frame.
    pay_seen = 12;
    got_fs   = 0;
    for (int c = 0; c < 1100 && !got_fs; c++) begin
      @(negedge clk);
      drive(0, 1, 32'h0, 0, 12'h000, 0, 12'h000);
      @(posedge clk);
      #1;
      if (bus.frameStart) got_fs = 1;
      else if (bus.outValid) pay_seen++;
    end
    check1("table frame end seen", got_fs, 1'b1);
    check32("table frame length", 32'(pay_seen), 32'(NPAY));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 1, 32'h0, 0, 12'h000, 0, 12'h000);
      @(posedge clk);
      #1;
      check32("sf from mid-frame load", bus.outData, 32'h7000_0000);
    end

    // Continuous inValid: comma, 1023 payload words, comma.
    reset_model_phase(2);
    for (int c = 0; c < 1100 && fs_seen < 2; c++)
      run_cycle(0, 1, $urandom, 0, 12'h000, 1, 12'(c));
    check32("continuous frames seen", 32'(fs_seen), 32'd2);
    check32("continuous frame length", 32'(last_len), 32'(NPAY));

    // inValid toggled 1010...
    reset_model_phase(2);
    for (int c = 0; c < 2200 && fs_seen < 2; c++)
      run_cycle(0, 1'(c % 2 == 0), $urandom, 0, 12'h000, 1, 12'h3E7);
    check32("toggle frames seen", 32'(fs_seen), 32'd2);
    check32("toggle frame length", 32'(last_len), 32'(NPAY));

    // Reset at payload 500 abandons the frame and clears the scaling factors.
    reset_model_phase(2);
    run_cycle(0, 1, $urandom, 1, 12'hBBB, 1, 12'h123);
    for (int c = 0; c < 600 && m_pos < 500; c++)
      run_cycle(0, 1, $urandom, c == 20, 12'hCCC, 1, 12'h9F9);
    check32("reached payload 500", 32'(m_pos), 32'd500);
    run_cycle(1, 1, $urandom, 0, 12'h000, 1, 12'h9F9);
    run_cycle(1, 1, $urandom, 0, 12'h000, 1, 12'h9F9);
    run_cycle(0, 1, 32'h0123_4567, 0, 12'h000, 1, 12'h9F9);
    check1("comma after rst", bus.frameStart, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 1, 32'hF123_4567, 0, 12'h000, 1, 12'h9F9);
      check32("sf cleared by rst", bus.outData, 32'h0123_4567);
    end

    // Randomized traffic.
    reset_model_phase(2);
    for (int c = 0; c < 6000; c++) begin
      run_cycle(1'($urandom_range(0, 2999) == 0), 1'($urandom_range(0, 9) < 7), $urandom,
                1'($urandom_range(0, 99) == 0), 12'($urandom), 1'($urandom_range(0, 1)),
                12'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
